bnn_conv_filter_pipe: RTL and testbench

//  Parametrised binary-weight (+1/-1) KxK convolution filter with multi-channel accumulation.

---
 rtl/bnn_conv_filter_pipe.sv | 198 +++++++++++++++++++
 tb/tb_bnn_conv_filter_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_filter_pipe.sv
// bnn_conv_filter_pipe
// Binary-weight (+1/-1) KxK convolution filter. Accumulates CH consecutive
// windows (one per input channel) into one output pixel, then applies an
// optional ReLU and signed saturation to OW bits.
// Pipeline: S1 sign/negate taps, S2 adder tree, accumulator, S3 output regs.
module bnn_conv_filter_pipe #(
  parameter int DW = 9,
  parameter int K = 5,
  parameter int CH = 1,
  parameter int OW = 15,
  parameter int RELU = 0,
  parameter logic [K*K-1:0] INIT_W = {(K*K){1'b1}}
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [K*K*DW-1:0]                     in_data,
  input  logic                                  w_wr_en,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] w_wr_ch,
  input  logic [K*K-1:0]                        w_wr_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OW-1:0]                         out_data,
  output logic                                  out_sat,
  output logic                                  busy
);
  localparam int KK = K * K;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int SW = DW + 1 + $clog2(KK);
  localparam int ACC_W = SW + $clog2(CH) + 1;
  // Working width for ReLU/saturation: wide enough for both the accumulator
  // and the output range limits.
  localparam int XW = ((ACC_W > OW) ? ACC_W : OW) + 1;
  localparam int NP = 1 << $clog2(KK);
  localparam logic signed [XW-1:0] SAT_MAX = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        ch_cnt_reg, ch_cnt_next;
  logic [KK-1:0]        w_mem [CH];
  logic [KK-1:0]        cur_mask;
  logic                 beat, last_beat, pipe_empty;

  logic [DW:0]          tap_w [KK];
  logic [DW:0]          s1_tap_reg [KK];
  logic                 s1_valid_reg, s1_first_reg;
  logic [SW-1:0]        tree [NP];
  logic [SW-1:0]        tree_sum;
  logic [SW-1:0]        s2_sum_reg;
  logic                 s2_valid_reg, s2_first_reg;
  logic [ACC_W-1:0]     acc_reg;
  logic signed [XW-1:0] acc_x, relu_x;
  logic [OW-1:0]        sat_data;
  logic                 sat_flag;
  logic [OW-1:0]        out_data_reg;
  logic                 out_sat_reg;

  assign in_ready   = (state_reg == IDLE) || (state_reg == ACC);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == OUT);
  assign out_data   = out_data_reg;
  assign out_sat    = out_sat_reg;
  assign beat       = in_valid && in_ready;
  assign last_beat  = (ch_cnt_reg == CW'(CH - 1));
  assign pipe_empty = !s1_valid_reg && !s2_valid_reg;
  assign cur_mask   = w_mem[ch_cnt_reg];

  // State and channel-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ch_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ch_cnt_reg <= ch_cnt_next;
    end
  end

  // Next-state logic: collect CH beats, let the pipeline drain, then present.
  always_comb begin
    state_next  = state_reg;
    ch_cnt_next = ch_cnt_reg;
    case (state_reg)
      IDLE, ACC: begin
        if (beat) begin
          if (last_beat) begin
            state_next  = DRAIN;
            ch_cnt_next = '0;
          end else begin
            state_next  = ACC;
            ch_cnt_next = ch_cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: if (pipe_empty) state_next = OUT;
      OUT:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Weight slots: writable only while idle; a same-cycle beat sees the old mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) w_mem[c] <= INIT_W;
    end else if (w_wr_en && (state_reg == IDLE) && (int'(w_wr_ch) < CH)) begin
      w_mem[w_wr_ch] <= w_wr_data;
    end
  end

  // Per-tap sign extension by one bit so negating the most negative tap is exact.
  generate
    for (genvar gi = 0; gi < KK; gi++) begin : g_tap
      logic [DW:0] ext;
      assign ext       = {in_data[(KK-1-gi)*DW + DW-1], in_data[(KK-1-gi)*DW +: DW]};
      assign tap_w[gi] = cur_mask[KK-1-gi] ? ext : -ext;
    end
  endgenerate

  // S1: register signed taps along with the first-channel marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      for (int i = 0; i < KK; i++) s1_tap_reg[i] <= '0;
    end else begin
      s1_valid_reg <= beat;
      s1_first_reg <= (ch_cnt_reg == '0);
      if (beat) begin
        for (int i = 0; i < KK; i++) s1_tap_reg[i] <= tap_w[i];
      end
    end
  end

  // Balanced adder tree over a power-of-two padded leaf set, reduced in place.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      tree[i] = (i < KK) ? SW'($signed(s1_tap_reg[i])) : '0;
    end
    for (int w = NP / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) tree[i] = tree[2*i] + tree[2*i+1];
    end
    tree_sum = tree[0];
  end

  // S2: register the tree sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sum_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_first_reg <= 1'b0;
    end else begin
      s2_sum_reg   <= tree_sum;
      s2_valid_reg <= s1_valid_reg;
      s2_first_reg <= s1_first_reg;
    end
  end

  // Channel accumulator: channel 0 loads, later channels add.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (s2_valid_reg) begin
      if (s2_first_reg) acc_reg <= ACC_W'($signed(s2_sum_reg));
      else              acc_reg <= acc_reg + ACC_W'($signed(s2_sum_reg));
    end
  end

  // Optional ReLU followed by signed saturation to OW bits.
  always_comb begin
    acc_x = XW'($signed(acc_reg));
    relu_x = acc_x;
    if ((RELU != 0) && (acc_x < 0)) relu_x = '0;
    sat_flag = 1'b0;
    sat_data = relu_x[OW-1:0];
    if (relu_x > SAT_MAX) begin
      sat_data = SAT_MAX[OW-1:0];
      sat_flag = 1'b1;
    end else if (relu_x < SAT_MIN) begin
      sat_data = SAT_MIN[OW-1:0];
      sat_flag = 1'b1;
    end
  end

  // S3: capture the result once the pipeline has emptied; held through OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg <= '0;
      out_sat_reg  <= 1'b0;
    end else if ((state_reg == DRAIN) && pipe_empty) begin
      out_data_reg <= sat_data;
      out_sat_reg  <= sat_flag;
    end
  end

endmodule

// File: tb/tb_bnn_conv_filter_pipe.sv
// Testbench for bnn_conv_filter_pipe. Two instances: u0 with defaults
// (CH=1, OW=15, RELU=0) and u1 with CH=3, OW=12, RELU=1. A behavioural model
// tracks accepted windows and weight masks and predicts every output.
module tb_bnn_conv_filter_pipe;
  localparam int KK = 25;
  localparam int W  = 225;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  in_data   [2];
  logic          w_wr_en   [2];
  logic [1:0]    w_wr_ch   [2];
  logic [KK-1:0] w_wr_data [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          out_sat   [2];
  logic          busy      [2];
  logic [14:0]   od0;
  logic [11:0]   od1;
  int            od [2];

  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    od[0] = int'($signed(od0));
    od[1] = int'($signed(od1));
  end

  bnn_conv_filter_pipe #(.DW(9), .K(5), .CH(1), .OW(15), .RELU(0)) u0 (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .w_wr_en(w_wr_en[0]), .w_wr_ch(w_wr_ch[0][0:0]),
    .w_wr_data(w_wr_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od0), .out_sat(out_sat[0]), .busy(busy[0])
  );

  bnn_conv_filter_pipe #(.DW(9), .K(5), .CH(3), .OW(12), .RELU(1)) u1 (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .w_wr_en(w_wr_en[1]), .w_wr_ch(w_wr_ch[1]),
    .w_wr_data(w_wr_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od1), .out_sat(out_sat[1]), .busy(busy[1])
  );

  function automatic int chn(int u);   return (u == 0) ? 1 : 3;   endfunction
  function automatic int owu(int u);   return (u == 0) ? 15 : 12; endfunction
  function automatic bit reluu(int u); return (u == 1);           endfunction

  // Signed window value: sum of +x or -x per tap according to the mask.
  function automatic int win_val(logic [W-1:0] d, logic [KK-1:0] m);
    int s = 0;
    for (int i = 0; i < KK; i++) begin
      s += (m[KK-1-i] ? 1 : -1) * int'($signed(d[(KK-1-i)*9 +: 9]));
    end
    return s;
  endfunction

  function automatic logic [W-1:0] fill(int v);
    logic [W-1:0] r;
    for (int i = 0; i < KK; i++) r[i*9 +: 9] = 9'(v);
    return r;
  endfunction

  task automatic chk(string name, int u, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [u%0d] t=%0t: got %0d, expected %0d", name, u, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          started = 1'b0;
  int          nb   [2];
  longint      acc  [2];
  bit          pend [2];
  int          tl   [2];
  int          ed   [2];
  int          es   [2];
  logic [KK-1:0] mask [2][3];
  bit          m_ov, m_rdy, m_idle;
  int          m_wc, m_v;
  longint      m_r, m_mx;

  initial begin
    for (int u = 0; u < 2; u++) begin
      nb[u] = 0; acc[u] = 0; pend[u] = 0; tl[u] = 0; ed[u] = 0; es[u] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst[0] && rst[1]) started = 1'b1;
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        nb[u] = 0; acc[u] = 0; pend[u] = 0;
        for (int c = 0; c < 3; c++) mask[u][c] = '1;
      end else begin
        m_ov   = pend[u] && (cyc - 1 >= tl[u] + 3);
        m_rdy  = !pend[u];
        m_idle = (nb[u] == 0) && !pend[u];
        m_wc   = (u == 0) ? int'(w_wr_ch[u][0]) : int'(w_wr_ch[u]);
        if (in_valid[u] && m_rdy) begin
          m_v = win_val(in_data[u], mask[u][nb[u]]);
          acc[u] = (nb[u] == 0) ? longint'(m_v) : acc[u] + m_v;
          nb[u]++;
          if (nb[u] == chn(u)) begin
            m_r = acc[u];
            if (reluu(u) && m_r < 0) m_r = 0;
            m_mx = (longint'(1) << (owu(u) - 1)) - 1;
            if (m_r > m_mx)           begin ed[u] = int'(m_mx);      es[u] = 1; end
            else if (m_r < -m_mx - 1) begin ed[u] = int'(-m_mx - 1); es[u] = 1; end
            else                      begin ed[u] = int'(m_r);       es[u] = 0; end
            pend[u] = 1; tl[u] = cyc; nb[u] = 0;
          end
        end
        if (w_wr_en[u] && m_idle && m_wc < chn(u)) mask[u][m_wc] = w_wr_data[u];
        if (m_ov && out_ready[u]) pend[u] = 0;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        chk("in_ready", u, int'(in_ready[u]), int'(!pend[u]));
        chk("busy", u, int'(busy[u]), int'(nb[u] > 0 || pend[u]));
        chk("out_valid", u, int'(out_valid[u]), int'(pend[u] && cyc >= tl[u] + 3));
        if (pend[u] && cyc >= tl[u] + 3) begin
          chk("out_data", u, od[u], ed[u]);
          chk("out_sat", u, int'(out_sat[u]), es[u]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(int u, logic [W-1:0] d);
    int n = 0;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    while (!in_ready[u] && n < 50) begin @(negedge clk); n++; end
    chk("send ready", u, int'(in_ready[u]), 1);
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  task automatic wr(int u, int ch, logic [KK-1:0] m);
    w_wr_en[u] = 1'b1; w_wr_ch[u] = 2'(ch); w_wr_data[u] = m;
    @(negedge clk);
    w_wr_en[u] = 1'b0;
  endtask

  task automatic take(int u, int exp_d, int exp_s, string name);
    int n = 0;
    while (!out_valid[u] && n < 50) begin @(negedge clk); n++; end
    chk({name, " valid"}, u, int'(out_valid[u]), 1);
    chk({name, " data"}, u, od[u], exp_d);
    chk({name, " sat"}, u, int'(out_sat[u]), exp_s);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; in_valid[u] = 1'b0; in_data[u] = '0; w_wr_en[u] = 1'b0;
      w_wr_ch[u] = '0; w_wr_data[u] = '0; out_ready[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("reset out_data", u, od[u], 0);
      chk("reset out_sat", u, int'(out_sat[u]), 0);
      chk("reset out_valid", u, int'(out_valid[u]), 0);
      chk("reset busy", u, int'(busy[u]), 0);
    end

    // T1: all taps 1, weights +1 -> 25, three cycles after the beat
    send(0, fill(1));
    n = 0;
    while (!out_valid[0] && n < 20) begin @(negedge clk); n++; end
    chk("T1 latency", 0, n, 3);
    take(0, 25, 0, "T1");

    // T5: output held under back-pressure; weight write while busy ignored
    send(0, fill(2));
    n = 0;
    while (!out_valid[0] && n < 20) begin @(negedge clk); n++; end
    repeat (10) begin
      w_wr_en[0] = 1'b1; w_wr_ch[0] = 2'd0; w_wr_data[0] = '0;
      @(negedge clk);
      chk("T5 hold data", 0, od[0], 50);
      chk("T5 in_ready", 0, int'(in_ready[0]), 0);
    end
    w_wr_en[0] = 1'b0;
    take(0, 50, 0, "T5");
    send(0, fill(1));
    take(0, 25, 0, "T5 mask kept");

    // T2: mask all 0, taps -256 -> +6400
    wr(0, 0, '0);
    send(0, fill(-256));
    take(0, 6400, 0, "T2");

    // Write and beat in the same idle cycle: beat uses the old (all-0) mask
    w_wr_en[0] = 1'b1; w_wr_ch[0] = 2'd0; w_wr_data[0] = '1;
    send(0, fill(1));
    w_wr_en[0] = 1'b0;
    take(0, -25, 0, "same-cycle old");
    send(0, fill(1));
    take(0, 25, 0, "same-cycle new");

    // T4 (RELU=0): mask 0, taps 3 -> -75; out-of-range slot write ignored
    wr(0, 0, '0);
    wr(0, 1, '1);
    send(0, fill(3));
    take(0, -75, 0, "T4 norelu");

    // T3: CH=3, OW=12, mask 0, taps -256 -> 19200 clips to 2047
    wr(1, 0, '0); wr(1, 1, '0); wr(1, 2, '0);
    wr(1, 3, '1);
    repeat (3) send(1, fill(-256));
    take(1, 2047, 1, "T3");

    // T4 (RELU=1): taps 3, mask 0 -> -225 -> 0, no saturation flag
    repeat (3) send(1, fill(3));
    take(1, 0, 0, "T4 relu");

    // T6: reset after the 2nd beat discards the partial sum
    send(1, fill(5));
    send(1, fill(5));
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("T6 busy after reset", 1, int'(busy[1]), 0);
    repeat (3) send(1, fill(1));
    take(1, 75, 0, "T6");

    // Randomised traffic checked by the model every cycle
    repeat (800) begin
      for (int u = 0; u < 2; u++) begin
        rst[u]      = ($urandom_range(199) == 0);
        in_valid[u] = ($urandom_range(2) != 0);
        if ($urandom_range(3) == 0) in_data[u] = fill(($urandom_range(1) != 0) ? -256 : 255);
        else for (int i = 0; i < KK; i++) in_data[u][i*9 +: 9] = 9'($urandom);
        w_wr_en[u] = ($urandom_range(7) == 0);
        w_wr_ch[u] = 2'($urandom);
        case ($urandom_range(3))
          0:       w_wr_data[u] = '0;
          1:       w_wr_data[u] = '1;
          default: w_wr_data[u] = 25'($urandom);
        endcase
        out_ready[u] = ($urandom_range(2) != 0);
      end
      @(negedge clk);
    end

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b0; in_valid[u] = 1'b0; w_wr_en[u] = 1'b0; out_ready[u] = 1'b1;
    end
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
